// File: rtl/serial_add_ctrl.sv
// Bit-serial adder: one full-adder cell stepped LSB first across WIDTH bits, with a start/busy/done handshake.
// Latency: done is high in the cycle after edge k+WIDTH for a start accepted at edge k; one add per WIDTH+2 cycles.
// Backpressure: start is only sampled in IDLE; requests in RUN/DONE are dropped without side effects.
module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MSB_ONE = WIDTH'(1) << (WIDTH - 1);
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] opa, opb, res, res_nxt;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             last_step;

    logic ha1_s, ha1_c, ha2_c, s_bit, c_next;

    // Full adder as two half adders plus an OR on the carries.
    assign ha1_s  = opa[0] ^ opb[0];
    assign ha1_c  = opa[0] & opb[0];
    assign s_bit  = ha1_s ^ carry;
    assign ha2_c  = ha1_s & carry;
    assign c_next = ha1_c | ha2_c;

    assign res_nxt   = (res >> 1) | (s_bit ? MSB_ONE : '0);
    assign last_step = (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Operand/result shifters; sum and cout move only on the final RUN step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        res   <= '0;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    res   <= res_nxt;
                    carry <= c_next;
                    cnt   <= cnt + 1'b1;
                    if (last_step) begin
                        sum  <= res_nxt;
                        cout <= c_next;
                    end
                end
                default: begin
                    cnt <= cnt;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl at WIDTH=8 and WIDTH=1 against a countdown/arithmetic reference model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start1, busy1, done1, cout1;
    logic [0:0] a1, b1, sum1;

    serial_add_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_add_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: rem counts remaining busy cycles; the result lands when one cycle remains.
    int         rem8 = 0;
    logic [8:0] pend8 = '0, exp8 = '0;
    int         rem1 = 0;
    logic [1:0] pend1 = '0, exp1 = '0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem8 <= 0;
            exp8 <= '0;
        end else if (rem8 == 0) begin
            if (start8) begin
                rem8  <= 8 + 1;
                pend8 <= {1'b0, a8} + {1'b0, b8};
            end
        end else begin
            rem8 <= rem8 - 1;
            if (rem8 == 2) exp8 <= pend8;
        end
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rem1 <= 0;
            exp1 <= '0;
        end else if (rem1 == 0) begin
            if (start1) begin
                rem1  <= 1 + 1;
                pend1 <= {1'b0, a1} + {1'b0, b1};
            end
        end else begin
            rem1 <= rem1 - 1;
            if (rem1 == 2) exp1 <= pend1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("busy8", 32'(busy8), 32'(rem8 != 0));
            chk("done8", 32'(done8), 32'(rem8 == 1));
            chk("res8",  32'({cout8, sum8}), 32'(exp8));
            chk("busy1", 32'(busy1), 32'(rem1 != 0));
            chk("done1", 32'(done1), 32'(rem1 == 1));
            chk("res1",  32'({cout1, sum1}), 32'(exp1));
        end
    end

    task automatic add8(input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] es, input logic ec,
                        input logic [7:0] pa, input logic [7:0] pb);
        int n;
        bit got;
        @(posedge clk);
        #1 a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0; a8 = pa; b8 = pb;
        n = 0;
        got = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n++;
            if (done8) begin
                got = 1;
                break;
            end
        end
        chk("lat8", 32'(n), 32'd9);
        if (got) begin
            chk("sum8_lit", 32'(sum8), 32'(es));
            chk("cout8_lit", 32'(cout8), 32'(ec));
            @(posedge clk);
            #1 chk("busy8_fall", 32'(busy8), 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] tbl1 [4];
        int dcount;
        int n;
        tbl1 = '{2'b00, 2'b01, 2'b01, 2'b10};

        rst = 1'b1;
        start8 = 1'b0; a8 = '0; b8 = '0;
        start1 = 1'b0; a1 = '0; b1 = '0;
        #1;
        chk("rst_busy", 32'(busy8), 32'd0);
        chk("rst_done", 32'(done8), 32'd0);
        chk("rst_sum",  32'(sum8),  32'd0);
        chk("rst_cout", 32'(cout8), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        add8(8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00);
        add8(8'h0F, 8'h01, 8'h10, 1'b0, 8'h5A, 8'hC3);
        add8(8'hFF, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00);
        add8(8'hFF, 8'hFF, 8'hFE, 1'b1, 8'h12, 8'h34);
        add8(8'h80, 8'h80, 8'h00, 1'b1, 8'h00, 8'h00);

        // start held high through RUN and DONE with different operands
        @(posedge clk);
        #1 a8 = 8'h35; b8 = 8'h4A; start8 = 1'b1;
        @(posedge clk);
        #1 a8 = 8'hFF; b8 = 8'hFF;
        dcount = 0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done8) dcount++;
        end
        chk("hold_dcount", 32'(dcount), 32'd1);
        chk("hold_sum", 32'(sum8), 32'h7F);
        chk("hold_cout", 32'(cout8), 32'd0);

        // result holds into the next RUN
        @(posedge clk);
        #1 a8 = 8'h10; b8 = 8'h20; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(negedge clk);
        chk("run_busy", 32'(busy8), 32'd1);
        chk("run_hold_sum", 32'(sum8), 32'h7F);
        repeat (10) @(posedge clk);

        // asynchronous reset mid-RUN
        @(posedge clk);
        #1 a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy8), 32'd0);
        chk("arst_done", 32'(done8), 32'd0);
        chk("arst_sum",  32'(sum8),  32'd0);
        chk("arst_cout", 32'(cout8), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        add8(8'h01, 8'h01, 8'h02, 1'b0, 8'hFF, 8'hFF);

        // WIDTH=1 exhaustive
        for (int v = 0; v < 4; v++) begin
            @(posedge clk);
            #1 a1 = 1'(v >> 1); b1 = 1'(v); start1 = 1'b1;
            @(posedge clk);
            #1 start1 = 1'b0;
            n = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                n++;
                if (done1) break;
            end
            chk("lat1", 32'(n), 32'd2);
            chk("w1_res", 32'({cout1, sum1}), 32'(tbl1[v]));
            @(posedge clk);
        end

        // randomized traffic, including held start and rare async reset pulses
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk);
            #1;
            start8 = ($urandom_range(0, 3) != 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
            start1 = 1'($urandom);
            a1 = 1'($urandom);
            b1 = 1'($urandom);
            if ($urandom_range(0, 249) == 0) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
        end
        start8 = 1'b0;
        start1 = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. Sequences one internal 1-bit full-adder cell, built from two half adders plus an OR gate, across a WIDTH-bit operand pair, LSB first, one bit per clock.
- Adds a start/busy/done handshake and registered result outputs.
- Provides a low-area adder for upstream blocks that can tolerate WIDTH+1 cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 1..32.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to add a and b; accepted only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- busy  output  1  high in RUN and DONE states.
- done  output  1  one-cycle pulse; sum/cout valid from this cycle onward.
- sum  output  WIDTH  registered result, a+b modulo 2^WIDTH.
- cout  output  1  registered carry-out of the MSB.

Behaviour:
- Reset, asynchronous, rst=1: state=IDLE, busy=0, done=0, sum=0, cout=0. Internal shift registers, carry flop and bit counter are cleared. Reset takes effect immediately, with no clock required.
- Reset mid-operation: the operation in progress is abandoned and done is never asserted for it. After rst deasserts, the block waits in IDLE for a new start.
- States and transitions:
  - IDLE: busy=0, done=0. If start=1 at an edge: latch a and b into shift registers opA and opB, carry=0, cnt=0, go to RUN.
  - RUN: busy=1, done=0. Each edge runs one bit step:
    - s_bit = opA[0]^opB[0]^carry
    - c_next = (opA[0]&opB[0]) | ((opA[0]^opB[0])&carry)
    - opA, opB shift right by 1; the result shift register takes s_bit into its MSB and shifts right.
    - carry <= c_next, cnt <= cnt+1.
    - On the edge where cnt==WIDTH-1: load sum from the completed result register (including this cycle's s_bit), load cout <= c_next, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. The next edge goes unconditionally to IDLE.
- Latency: start is accepted at edge k. done is high in the cycle following edge k+WIDTH. busy falls at edge k+WIDTH+1.
- Back-to-back: the next start is accepted no earlier than edge k+WIDTH+2, which gives a throughput of one add per WIDTH+2 cycles.
- start while busy, in RUN or DONE, is ignored and has no side effects. start held high continuously gives repeated adds at the WIDTH+2 cycle rate.
- Operand stability: changes on a or b after the accepting edge do not affect the result in progress.
- sum and cout change only on the RUN→DONE edge or on reset. They hold the last result indefinitely, including across later IDLE cycles and during the next RUN.
- Counter width is clog2(WIDTH)+1 bits. For WIDTH=1 the block makes a single RUN step, and cout equals the half-adder carry a&b.
- The result must equal the full (WIDTH+1)-bit sum {cout,sum} = a+b for all operand values.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, start pulse at edge k -> done high after edge k+8; sum=0x00, cout=0; busy low after edge k+9.
- a=0x0F, b=0x01 -> sum=0x10, cout=0. a=0xFF, b=0x01 -> sum=0x00, cout=1. a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- a=0x35, b=0x4A, start at edge k; drive start=1 with a=b=0xFF during RUN and DONE -> only one done pulse; sum=0x7F, cout=0; sum/cout unchanged until the next start accepted in IDLE.
- Start 0xAA+0x55, assert rst during RUN (asynchronously, between edges) -> busy, done, sum and cout go to 0 immediately. After release, start 0x01+0x01 -> sum=0x02, cout=0 in the expected WIDTH+1 cycles.
- Change a and b to 0x00 one cycle after accepting 0x80+0x80 -> sum=0x00, cout=1, proving the operands were latched.
- WIDTH=1, exhaustive {a,b} = 00, 01, 10, 11 -> {cout,sum} = 00, 01, 01, 10, each with done asserted 1 cycle after the RUN step.
